// File: rtl/shaper_coef_ctrl.sv
// shaper_coef_ctrl: runtime coefficient controller for the parallel IIR shaper bank.
// Host writes land in a shadow bank; a commit swaps the whole shadow bank into the
// active bank on the next sample strobe and then holds sect_clear for a flush window,
// so the shaper never runs a sample on a mix of old and new coefficients.
// Optional feature macro: SHAPER_COEF_READBACK_EN adds a registered readback port
// (rd_addr, rd_sel, rd_data) for the shadow or active bank.
module shaper_coef_ctrl #(
    parameter int COEF_W       = 16,
    parameter int N_SECT       = 6,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [4:0]                     wr_addr,
    input  logic [COEF_W-1:0]              wr_data,
    input  logic                           commit_req,
    output logic                           commit_ack,
    input  logic                           sample_en,
    output logic [N_SECT*4*COEF_W-1:0]     coef_bus,
    output logic                           sect_clear,
    output logic                           busy,
    output logic                           addr_err
`ifdef SHAPER_COEF_READBACK_EN
    ,
    input  logic [4:0]                     rd_addr,
    input  logic                           rd_sel,
    output logic [COEF_W-1:0]              rd_data
`endif
);

    localparam int N_ENT = N_SECT * 4;
    localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int BUS_W = N_ENT * COEF_W;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SAMPLE,
        SWAP,
        FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [COEF_W-1:0]    shadow_q [N_ENT];
    logic [COEF_W-1:0]    shadow_d [N_ENT];
    logic [BUS_W-1:0]     active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sect_clear_q, sect_clear_d;
    logic                 ack_q, ack_d;
    logic                 addr_err_q, addr_err_d;

    logic                 wr_fire;
    logic                 wr_legal;
    logic [IDX_W-1:0]     wr_idx;

    // Writes are only accepted while idle so a commit in flight sees a frozen shadow bank.
    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_legal = ({1'b0, wr_addr} < 6'(N_ENT));
    assign wr_idx   = wr_addr[IDX_W-1:0];

    assign coef_bus   = active_q;
    assign sect_clear = sect_clear_q;
    assign commit_ack = ack_q;
    assign addr_err   = addr_err_q;

    // Next-state logic: shadow writes, commit sequencing, bank swap and flush countdown.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        cnt_d        = cnt_q;
        sect_clear_d = sect_clear_q;
        ack_d        = 1'b0;
        addr_err_d   = addr_err_q;

        if (wr_fire) begin
            if (wr_legal) begin
                shadow_d[wr_idx] = wr_data;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = WAIT_SAMPLE;
                end
            end
            WAIT_SAMPLE: begin
                if (sample_en) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                for (int k = 0; k < N_ENT; k++) begin
                    active_d[k*COEF_W +: COEF_W] = shadow_q[k];
                end
                sect_clear_d = 1'b1;
                cnt_d        = CNT_W'(FLUSH_CYCLES - 1);
                state_d      = FLUSH;
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    sect_clear_d = 1'b0;
                    ack_d        = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, both banks and all registered outputs; reset aborts any commit in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int k = 0; k < N_ENT; k++) begin
                shadow_q[k] <= '0;
            end
            active_q     <= '0;
            cnt_q        <= '0;
            sect_clear_q <= 1'b0;
            ack_q        <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            cnt_q        <= cnt_d;
            sect_clear_q <= sect_clear_d;
            ack_q        <= ack_d;
            addr_err_q   <= addr_err_d;
        end
    end

`ifdef SHAPER_COEF_READBACK_EN
    logic [COEF_W-1:0] rd_data_q, rd_data_d;
    logic              rd_legal;
    logic [IDX_W-1:0]  rd_idx;

    assign rd_legal = ({1'b0, rd_addr} < 6'(N_ENT));
    assign rd_idx   = rd_addr[IDX_W-1:0];
    assign rd_data  = rd_data_q;

    // Readback mux: selects shadow or active entry; out-of-range addresses read zero.
    always_comb begin
        rd_data_d = '0;
        if (rd_legal) begin
            if (rd_sel) begin
                rd_data_d = active_q[rd_idx*COEF_W +: COEF_W];
            end else begin
                rd_data_d = shadow_q[rd_idx];
            end
        end
    end

    // Readback register gives a one-cycle read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_shaper_coef_ctrl.sv
// tb_shaper_coef_ctrl: directed-plus-random bench for shaper_coef_ctrl with a
// bank-level reference model (shadow/active arrays and expected flush timing).
module tb_shaper_coef_ctrl;

    localparam int COEF_W = 16;
    localparam int N_SECT = 6;
    localparam int FC     = 16;
    localparam int N_ENT  = N_SECT * 4;

    logic                        clock = 1'b0;
    logic                        reset;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [4:0]                  wr_addr;
    logic [COEF_W-1:0]           wr_data;
    logic                        commit_req;
    logic                        commit_ack;
    logic                        sample_en;
    logic [N_ENT*COEF_W-1:0]     coef_bus;
    logic                        sect_clear;
    logic                        busy;
    logic                        addr_err;
`ifdef SHAPER_COEF_READBACK_EN
    logic [4:0]                  rd_addr;
    logic                        rd_sel;
    logic [COEF_W-1:0]           rd_data;
`endif

    int checks = 0;
    int fails  = 0;

    logic [COEF_W-1:0] shadow_m [N_ENT];
    logic [COEF_W-1:0] active_m [N_ENT];
    logic              addr_err_m;

    shaper_coef_ctrl #(
        .COEF_W       (COEF_W),
        .N_SECT       (N_SECT),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .sample_en  (sample_en),
        .coef_bus   (coef_bus),
        .sect_clear (sect_clear),
        .busy       (busy),
        .addr_err   (addr_err)
`ifdef SHAPER_COEF_READBACK_EN
        ,
        .rd_addr    (rd_addr),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data)
`endif
    );

    // Free-running system clock.
    always #5 clock = ~clock;

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBus(input string tag);
        for (int k = 0; k < N_ENT; k++) begin
            checkOutput($sformatf("%s_coef%0d", tag, k),
                        32'(coef_bus[k*COEF_W +: COEF_W]), 32'(active_m[k]));
        end
    endtask

    task automatic modelReset;
        for (int k = 0; k < N_ENT; k++) begin
            shadow_m[k] = '0;
            active_m[k] = '0;
        end
        addr_err_m = 1'b0;
    endtask

    // One host write, optionally with commit_req in the same cycle.
    task automatic applyStimulus(input int addr, input logic [COEF_W-1:0] data, input bit with_commit);
        wr_valid   = 1'b1;
        wr_addr    = 5'(addr);
        wr_data    = data;
        commit_req = with_commit;
        tick();
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        if (addr < N_ENT) shadow_m[addr] = data;
        else              addr_err_m     = 1'b1;
    endtask

    task automatic issueCommit;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        checkOutput("busy_after_commit", 32'(busy), 32'd1);
        checkOutput("wr_ready_after_commit", 32'(wr_ready), 32'd0);
    endtask

    task automatic randomWrites(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(int'($urandom_range(0, N_ENT - 1)), COEF_W'($urandom), 1'b0);
        end
    endtask

    // Drives the sample strobe after wait_cycles and follows the swap/flush/ack sequence.
    // disturb: attempt a write and a second commit during flush.
    // reset_at: if nonzero, assert reset in that flush cycle and abort.
    task automatic runCommit(input int wait_cycles, input bit disturb, input int reset_at);
        int n;
        for (int i = 0; i < wait_cycles; i++) begin
            checkOutput("busy_waiting", 32'(busy), 32'd1);
            checkOutput("clear_waiting", 32'(sect_clear), 32'd0);
            tick();
        end
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        checkOutput("clear_at_swap", 32'(sect_clear), 32'd0);
        checkBus("bus_at_swap");
        tick();
        for (int k = 0; k < N_ENT; k++) active_m[k] = shadow_m[k];
        checkBus("bus_after_swap");
        n = 0;
        while (sect_clear === 1'b1 && n < 4 * FC + 10) begin
            n++;
            checkOutput("ack_during_flush", 32'(commit_ack), 32'd0);
            if (disturb && n == 2) begin
                wr_valid   = 1'b1;
                wr_addr    = 5'd1;
                wr_data    = 16'd99;
                commit_req = 1'b1;
                checkOutput("wr_ready_flush", 32'(wr_ready), 32'd0);
            end
            if (reset_at == n) begin
                reset = 1'b1;
                #1;
                modelReset();
                checkOutput("clear_on_reset", 32'(sect_clear), 32'd0);
                checkOutput("ack_on_reset", 32'(commit_ack), 32'd0);
                checkBus("bus_on_reset");
                tick();
                reset = 1'b0;
                for (int i = 0; i < FC + 4; i++) begin
                    checkOutput("ack_after_abort", 32'(commit_ack), 32'd0);
                    tick();
                end
                checkOutput("wr_ready_after_abort", 32'(wr_ready), 32'd1);
                checkOutput("busy_after_abort", 32'(busy), 32'd0);
                checkOutput("addr_err_after_abort", 32'(addr_err), 32'd0);
                return;
            end
            tick();
            wr_valid   = 1'b0;
            commit_req = 1'b0;
        end
        checkOutput("flush_len", 32'(n), 32'(FC));
        checkOutput("ack_pulse", 32'(commit_ack), 32'd1);
        checkOutput("wr_ready_at_ack", 32'(wr_ready), 32'd1);
        checkOutput("busy_at_ack", 32'(busy), 32'd0);
        tick();
        checkOutput("ack_single", 32'(commit_ack), 32'd0);
        checkOutput("no_queued_commit", 32'(busy), 32'd0);
        tick();
        checkOutput("ack_single2", 32'(commit_ack), 32'd0);
        checkBus("bus_stable");
    endtask

    // Directed sequence with randomized data and wait lengths.
    initial begin
        reset      = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        commit_req = 1'b0;
        sample_en  = 1'b0;
`ifdef SHAPER_COEF_READBACK_EN
        rd_addr    = '0;
        rd_sel     = 1'b0;
`endif
        modelReset();
        #12;
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_clear", 32'(sect_clear), 32'd0);
        checkOutput("rst_ack", 32'(commit_ack), 32'd0);
        checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
        checkBus("rst_bus");
        reset = 1'b0;
        tick();

`ifdef SHAPER_COEF_READBACK_EN
        $display("[TB] readback");
        applyStimulus(3, 16'(-361), 1'b0);
        rd_addr = 5'd3;
        rd_sel  = 1'b0;
        tick();
        checkOutput("rd_shadow", 32'(rd_data), 32'(shadow_m[3]));
        rd_sel = 1'b1;
        tick();
        checkOutput("rd_active", 32'(rd_data), 32'(active_m[3]));
        rd_addr = 5'd30;
        rd_sel  = 1'b0;
        tick();
        checkOutput("rd_out_of_range", 32'(rd_data), 32'd0);
`endif

        $display("[TB] basic commit");
        applyStimulus(0, 16'(-3), 1'b0);
        applyStimulus(4, 16'd746, 1'b0);
        checkBus("shadow_no_leak");
        issueCommit();
        runCommit(5, 1'b0, 0);

        $display("[TB] write lockout and dropped request");
        randomWrites(3);
        issueCommit();
        runCommit(int'($urandom_range(0, 3)), 1'b1, 0);

        $display("[TB] sample strobe ignored in idle");
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        checkOutput("idle_sample_busy", 32'(busy), 32'd0);
        checkOutput("idle_sample_clear", 32'(sect_clear), 32'd0);

        $display("[TB] same-cycle write and commit");
        applyStimulus(7, 16'd296, 1'b1);
        checkOutput("busy_same_cycle", 32'(busy), 32'd1);
        runCommit(int'($urandom_range(0, 4)), 1'b0, 0);

        $display("[TB] illegal address");
        applyStimulus(24, 16'd5, 1'b0);
        checkOutput("addr_err_set", 32'(addr_err), 32'(addr_err_m));
        applyStimulus(int'($urandom_range(25, 31)), COEF_W'($urandom), 1'b0);
        checkBus("bus_after_illegal");
        issueCommit();
        runCommit(1, 1'b0, 0);
        checkOutput("addr_err_sticky", 32'(addr_err), 32'd1);

        $display("[TB] random commits");
        for (int r = 0; r < 4; r++) begin
            randomWrites(int'($urandom_range(1, 6)));
            applyStimulus(int'($urandom_range(0, N_ENT - 1)), COEF_W'($urandom), 1'b1);
            runCommit(int'($urandom_range(0, 3)), 1'b0, 0);
        end

        $display("[TB] reset mid-flush");
        randomWrites(4);
        issueCommit();
        runCommit(2, 1'b0, 3);
        checkBus("bus_after_reset");

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
